lock_scheduler: RTL and testbench
=================================

LOCK_SCHEDULER -- requirements
Module: lock_scheduler

Interface
REQ-001 Parameter LOW_LVL, default 6'd0, is the water level at which the left (downstream) gate may open.
REQ-002 Parameter HIGH_LVL, default 6'd40, is the water level at which the right (upstream) gate may open; LOW_LVL < HIGH_LVL.
REQ-003 clk  input  1  is the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset.
REQ-005 arrive_left  input  1  is a one-cycle pulse for a boat waiting at the left gate.
REQ-006 arrive_right  input  1  is a one-cycle pulse for a boat waiting at the right gate.
REQ-007 boat_in  input  1  is the chamber occupancy sensor (1 = boat in chamber), already synchronous to clk.
REQ-008 water_level  input  6  is the current chamber level from the water datapath, unsigned.
REQ-009 fill  output  1  commands the water datapath to raise the level.
REQ-010 drain  output  1  commands the water datapath to lower the level.
REQ-011 gate_left  output  1  opens the left gate (1 = open).
REQ-012 gate_right  output  1  opens the right gate (1 = open).
REQ-013 grant_right  output  1  gives the entry side of the current service (0 = left, 1 = right); valid while busy.
REQ-014 busy  output  1  is high in every state except IDLE.
REQ-015 boats_served  output  8  counts completed passages.

Function
REQ-016 The FSM states SHALL be IDLE, EQUALIZE, OPEN_ENTRY, CLOSE_ENTRY, TRANSFER, OPEN_EXIT, CLOSE_EXIT.
REQ-017 Level predicates: at_low = (water_level <= LOW_LVL); at_high = (water_level >= HIGH_LVL); the entry level is LOW for left entry and HIGH for right entry, and the exit level is the opposite.
REQ-018 pend_left and pend_right SHALL be set on their arrive pulse and cleared in the cycle IDLE grants that side; if set and clear coincide, set SHALL win.
REQ-019 IDLE arbitration with only one side pending: grant that side.
REQ-020 IDLE arbitration with both sides pending: grant the side whose entry level is already met (left if at_low, right if at_high); if neither is met, grant the side opposite last_served (round-robin bit, reset 0 = left served last, so right wins first).
REQ-021 IDLE -> OPEN_ENTRY if the granted side's entry level is met, else IDLE -> EQUALIZE; grant_right is registered at grant.
REQ-022 EQUALIZE: fill=1 for right entry while !at_high, drain=1 for left entry while !at_low; go to OPEN_ENTRY in the cycle after the entry level is met.
REQ-023 OPEN_ENTRY: the entry-side gate SHALL be 1; move to CLOSE_ENTRY the cycle after boat_in=1 is sampled.
REQ-024 CLOSE_ENTRY: both gates SHALL be 0 for exactly one cycle, then TRANSFER.
REQ-025 TRANSFER: fill=1 for left entry while !at_high, drain=1 for right entry while !at_low; go to OPEN_EXIT once the exit level is met.
REQ-026 OPEN_EXIT: the exit-side gate SHALL be 1; move to CLOSE_EXIT the cycle after boat_in=0 is sampled.
REQ-027 CLOSE_EXIT: gates SHALL be 0 for one cycle; boats_served SHALL increment by 1 (wrapping 255 -> 0); last_served SHALL take the entry side; then IDLE.
REQ-028 fill and drain SHALL never both be 1; neither SHALL be 1 while any gate is 1.
REQ-029 gate_left and gate_right SHALL never both be 1.
REQ-030 fill, drain and gate outputs SHALL be decoded from state, grant_right and water_level only; in IDLE they SHALL all be 0.
REQ-031 Arrivals during a service SHALL only set pending flags and SHALL not affect the current service.

Reset
REQ-032 reset SHALL put the FSM in IDLE and clear pend_left, pend_right, last_served, grant_right and boats_served.
REQ-033 In the cycle after reset is sampled high, all outputs SHALL be 0, regardless of the state when reset was asserted, including mid-fill or with a gate open.

Verification
REQ-034 Level 0, arrive_left pulse -> OPEN_ENTRY with gate_left=1; boat_in=1 -> one closed cycle; fill=1 until level 40; gate_right=1; boat_in=0 -> boats_served=1.
REQ-035 Level 0, arrive_right pulse -> EQUALIZE with fill=1 until level 40, then gate_right=1; the passage ends with drain until level 0, then gate_left=1.
REQ-036 Level 20, arrive_left and arrive_right in the same cycle, after reset -> grant_right=1; after CLOSE_EXIT the left is served next with no new pulses.
REQ-037 Level 40, both pending -> right is granted because at_high holds, and it goes directly to OPEN_ENTRY.
REQ-038 Reset asserted during TRANSFER with fill=1 -> next cycle fill=0, busy=0, boats_served=0, pending flags cleared.
REQ-039 Run 256 passages -> boats_served wraps to 0; check fill&drain, gate&fill|drain and gate_left&gate_right are never 1 in any cycle.

Source files
------------

// File: rtl/lock_if.sv
// Boat-lock control bus: arrival requests and chamber sensing in, gate/water
// commands and service status out.
interface lock_if;
    logic       arrive_left;
    logic       arrive_right;
    logic       boat_in;
    logic [5:0] water_level;
    logic       fill;
    logic       drain;
    logic       gate_left;
    logic       gate_right;
    logic       grant_right;
    logic       busy;
    logic [7:0] boats_served;

    modport master (
        output arrive_left, arrive_right, boat_in, water_level,
        input  fill, drain, gate_left, gate_right, grant_right, busy, boats_served
    );

    modport slave (
        input  arrive_left, arrive_right, boat_in, water_level,
        output fill, drain, gate_left, gate_right, grant_right, busy, boats_served
    );
endinterface

// File: rtl/lock_scheduler.sv
// Two-gate canal lock scheduler: arbitrates waiting boats, equalizes the
// chamber, and sequences the gates and water commands for one passage at a time.
module lock_scheduler #(
    parameter logic [5:0] LOW_LVL  = 6'd0,
    parameter logic [5:0] HIGH_LVL = 6'd40
) (
    input  logic clk,
    input  logic reset,
    lock_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        EQUALIZE,
        OPEN_ENTRY,
        CLOSE_ENTRY,
        TRANSFER,
        OPEN_EXIT,
        CLOSE_EXIT
    } state_t;

    state_t     state_q, state_d;
    logic       pend_left_q, pend_left_d;
    logic       pend_right_q, pend_right_d;
    logic       last_served_q, last_served_d;
    logic       grant_right_q, grant_right_d;
    logic [7:0] served_q, served_d;

    logic at_low, at_high;
    logic entry_met, exit_met;
    logic pick_right;
    logic fill_c, drain_c, gate_left_c, gate_right_c;

    assign at_low    = (bus.water_level <= LOW_LVL);
    assign at_high   = (bus.water_level >= HIGH_LVL);
    assign entry_met = grant_right_q ? at_high : at_low;
    assign exit_met  = grant_right_q ? at_low  : at_high;

    // A side whose entry level already holds wins; otherwise round-robin.
    assign pick_right = pend_right_q &
                        (!pend_left_q | (!at_low & (at_high | !last_served_q)));

    always_comb begin
        state_d       = state_q;
        pend_left_d   = pend_left_q;
        pend_right_d  = pend_right_q;
        last_served_d = last_served_q;
        grant_right_d = grant_right_q;
        served_d      = served_q;

        case (state_q)
            IDLE: begin
                if (pend_left_q || pend_right_q) begin
                    grant_right_d = pick_right;
                    if (pick_right) begin
                        pend_right_d = 1'b0;
                        state_d      = at_high ? OPEN_ENTRY : EQUALIZE;
                    end else begin
                        pend_left_d  = 1'b0;
                        state_d      = at_low ? OPEN_ENTRY : EQUALIZE;
                    end
                end
            end
            EQUALIZE: begin
                if (entry_met) state_d = OPEN_ENTRY;
            end
            OPEN_ENTRY: begin
                if (bus.boat_in) state_d = CLOSE_ENTRY;
            end
            CLOSE_ENTRY: begin
                state_d = TRANSFER;
            end
            TRANSFER: begin
                if (exit_met) state_d = OPEN_EXIT;
            end
            OPEN_EXIT: begin
                if (!bus.boat_in) state_d = CLOSE_EXIT;
            end
            CLOSE_EXIT: begin
                served_d      = served_q + 8'd1;
                last_served_d = grant_right_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new arrival in the same cycle as a grant keeps the request pending.
        pend_left_d  = pend_left_d  | bus.arrive_left;
        pend_right_d = pend_right_d | bus.arrive_right;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pend_left_q   <= 1'b0;
            pend_right_q  <= 1'b0;
            last_served_q <= 1'b0;
            grant_right_q <= 1'b0;
            served_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            pend_left_q   <= pend_left_d;
            pend_right_q  <= pend_right_d;
            last_served_q <= last_served_d;
            grant_right_q <= grant_right_d;
            served_q      <= served_d;
        end
    end

    // Water and gate commands come only from state, side and level, so a
    // reset returns every command to zero on the very next cycle.
    always_comb begin
        fill_c       = 1'b0;
        drain_c      = 1'b0;
        gate_left_c  = 1'b0;
        gate_right_c = 1'b0;
        case (state_q)
            EQUALIZE: begin
                fill_c  =  grant_right_q & !at_high;
                drain_c = !grant_right_q & !at_low;
            end
            OPEN_ENTRY: begin
                gate_left_c  = !grant_right_q;
                gate_right_c =  grant_right_q;
            end
            TRANSFER: begin
                fill_c  = !grant_right_q & !at_high;
                drain_c =  grant_right_q & !at_low;
            end
            OPEN_EXIT: begin
                gate_left_c  =  grant_right_q;
                gate_right_c = !grant_right_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.fill         = fill_c;
    assign bus.drain        = drain_c;
    assign bus.gate_left    = gate_left_c;
    assign bus.gate_right   = gate_right_c;
    assign bus.grant_right  = grant_right_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.boats_served = served_q;

endmodule

// File: tb/tb_lock_scheduler.sv
// Directed bench for lock_scheduler with a simple chamber water model that
// moves one level per cycle under fill/drain.
module tb_lock_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lock_if bus();

    logic [5:0] lvl = 6'd0;
    logic       lvl_force;
    logic [5:0] lvl_val;
    int checks = 0;
    int errors = 0;

    assign bus.water_level = lvl;

    lock_scheduler #(.LOW_LVL(6'd0), .HIGH_LVL(6'd40)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Chamber model: one level step per cycle while commanded.
    always @(posedge clk) begin
        if (lvl_force)
            lvl <= lvl_val;
        else if (bus.fill && lvl < 6'd63)
            lvl <= lvl + 6'd1;
        else if (bus.drain && lvl > 6'd0)
            lvl <= lvl - 6'd1;
    end

    // Safety invariants sampled every cycle away from the active edge.
    always @(negedge clk) begin
        checks++;
        assert (!(bus.fill && bus.drain) &&
                !((bus.gate_left || bus.gate_right) && (bus.fill || bus.drain)) &&
                !(bus.gate_left && bus.gate_right))
        else begin
            errors++;
            $error("FAIL safety observed fill=%b drain=%b gl=%b gr=%b expected no overlap",
                   bus.fill, bus.drain, bus.gate_left, bus.gate_right);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_level(input logic [5:0] v);
        lvl_force = 1'b1;
        lvl_val   = v;
        tick();
        lvl_force = 1'b0;
    endtask

    task automatic pulse(input logic l, input logic r);
        bus.arrive_left  = l;
        bus.arrive_right = r;
        tick();
        bus.arrive_left  = 1'b0;
        bus.arrive_right = 1'b0;
    endtask

    task automatic wait_gate(input string tag);
        int n = 0;
        while (!(bus.gate_left || bus.gate_right) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " gate_timeout"}, int'(bus.gate_left | bus.gate_right), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " idle_timeout"}, int'(bus.busy), 0);
    endtask

    task automatic passage(input string tag);
        wait_gate({tag, " entry"});
        bus.boat_in = 1'b1;
        tick();
        wait_gate({tag, " exit"});
        bus.boat_in = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        reset            = 1'b1;
        bus.arrive_left  = 1'b0;
        bus.arrive_right = 1'b0;
        bus.boat_in      = 1'b0;
        lvl_force        = 1'b1;
        lvl_val          = 6'd0;
        tick();
        tick();
        lvl_force = 1'b0;

        chk("rst busy", int'(bus.busy), 0);
        chk("rst fill_drain", int'(bus.fill | bus.drain), 0);
        chk("rst gates", int'(bus.gate_left | bus.gate_right), 0);
        chk("rst served", int'(bus.boats_served), 0);
        chk("rst grant", int'(bus.grant_right), 0);
        reset = 1'b0;

        // Left entry at low level, lifted to high, exits right.
        pulse(1'b1, 1'b0);
        chk("t1 pending idle", int'(bus.busy), 0);
        tick();
        chk("t1 busy", int'(bus.busy), 1);
        chk("t1 gate_left", int'(bus.gate_left), 1);
        chk("t1 gate_right", int'(bus.gate_right), 0);
        chk("t1 grant", int'(bus.grant_right), 0);
        bus.boat_in = 1'b1;
        tick();
        chk("t1 closed gates", int'(bus.gate_left | bus.gate_right), 0);
        chk("t1 closed busy", int'(bus.busy), 1);
        tick();
        chk("t1 fill", int'(bus.fill), 1);
        chk("t1 drain", int'(bus.drain), 0);
        wait_gate("t1 exit");
        chk("t1 exit gate_right", int'(bus.gate_right), 1);
        chk("t1 exit level", int'(lvl), 40);
        chk("t1 exit fill", int'(bus.fill), 0);
        bus.boat_in = 1'b0;
        tick();
        chk("t1 close_exit gates", int'(bus.gate_left | bus.gate_right), 0);
        chk("t1 close_exit served", int'(bus.boats_served), 0);
        tick();
        chk("t1 served", int'(bus.boats_served), 1);
        chk("t1 idle", int'(bus.busy), 0);

        // Right entry from low level needs equalizing first.
        set_level(6'd0);
        pulse(1'b0, 1'b1);
        tick();
        chk("t2 grant", int'(bus.grant_right), 1);
        chk("t2 eq fill", int'(bus.fill), 1);
        chk("t2 eq gates", int'(bus.gate_left | bus.gate_right), 0);
        wait_gate("t2 entry");
        chk("t2 gate_right", int'(bus.gate_right), 1);
        chk("t2 entry level", int'(lvl), 40);
        bus.boat_in = 1'b1;
        tick();
        tick();
        chk("t2 drain", int'(bus.drain), 1);
        chk("t2 no fill", int'(bus.fill), 0);
        wait_gate("t2 exit");
        chk("t2 gate_left", int'(bus.gate_left), 1);
        chk("t2 exit level", int'(lvl), 0);
        bus.boat_in = 1'b0;
        tick();
        tick();
        chk("t2 served", int'(bus.boats_served), 2);
        chk("t2 idle", int'(bus.busy), 0);

        // Simultaneous arrivals at mid level: round-robin picks right first.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t3 served reset", int'(bus.boats_served), 0);
        set_level(6'd20);
        pulse(1'b1, 1'b1);
        tick();
        chk("t3 grant right", int'(bus.grant_right), 1);
        chk("t3 eq fill", int'(bus.fill), 1);
        passage("t3 first");
        chk("t3 served1", int'(bus.boats_served), 1);
        tick();
        chk("t3 left next busy", int'(bus.busy), 1);
        chk("t3 left next grant", int'(bus.grant_right), 0);
        chk("t3 left gate", int'(bus.gate_left), 1);
        passage("t3 second");
        chk("t3 served2", int'(bus.boats_served), 2);

        // Right served last, both pending at high level: level beats round-robin.
        pulse(1'b0, 1'b1);
        tick();
        chk("t4 pre grant", int'(bus.grant_right), 1);
        passage("t4 pre");
        set_level(6'd40);
        pulse(1'b1, 1'b1);
        tick();
        chk("t4 grant right", int'(bus.grant_right), 1);
        chk("t4 direct gate_right", int'(bus.gate_right), 1);
        chk("t4 no fill", int'(bus.fill), 0);
        passage("t4 right");
        tick();
        chk("t4 left after", int'(bus.grant_right), 0);
        chk("t4 left busy", int'(bus.busy), 1);
        passage("t4 left");
        chk("t4 served", int'(bus.boats_served), 5);

        // Reset mid-transfer while filling, with a pending arrival.
        set_level(6'd0);
        pulse(1'b1, 1'b0);
        tick();
        bus.boat_in = 1'b1;
        tick();
        tick();
        tick();
        pulse(1'b0, 1'b1);
        chk("t5 filling", int'(bus.fill), 1);
        chk("t5 busy", int'(bus.busy), 1);
        reset = 1'b1;
        tick();
        chk("t5 fill off", int'(bus.fill), 0);
        chk("t5 busy off", int'(bus.busy), 0);
        chk("t5 served", int'(bus.boats_served), 0);
        chk("t5 gates", int'(bus.gate_left | bus.gate_right), 0);
        chk("t5 grant", int'(bus.grant_right), 0);
        reset       = 1'b0;
        bus.boat_in = 1'b0;
        tick();
        tick();
        tick();
        chk("t5 pend cleared", int'(bus.busy), 0);

        // 256 passages wrap the counter.
        set_level(6'd0);
        for (int i = 0; i < 256; i++) begin
            if (lvl == 6'd0) pulse(1'b1, 1'b0);
            else             pulse(1'b0, 1'b1);
            passage("t6");
            if (i == 254) chk("t6 served255", int'(bus.boats_served), 255);
        end
        chk("t6 wrap", int'(bus.boats_served), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
